// File: rtl/adder_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : adder_sum_accumulator
// Purpose  : Sums BLOCK_LEN valid adder results into one block total and
//            offers that total on a valid/ready output with backpressure.
//            Build option ACC_SATURATE_EN makes the accumulator clamp at its
//            maximum value instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module adder_sum_accumulator #(
    parameter int ADDER_WIDTH = 13,
    parameter int ACC_WIDTH   = 24,
    parameter int BLOCK_LEN   = 16,
    parameter int CNT_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sum_valid,
    input  logic [ADDER_WIDTH:0]   sum,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic                   busy,
    output logic                   overflow,
    output logic                   dropped
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_LAST    = CNT_WIDTH'(BLOCK_LEN - 1);
    localparam logic [ACC_WIDTH-1:0] C_ACC_MAX = '1;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   r_acc_out;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_acc_valid;
    logic                   r_busy;
    logic                   r_overflow;
    logic                   r_dropped;

    logic [ACC_WIDTH:0]     w_sum_wide;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic                   w_carry;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_handshake;
    logic                   w_clear;

    assign w_accept    = (r_state == ST_ACCUM) && sum_valid;
    assign w_last      = w_accept && (r_count == C_LAST);
    assign w_handshake = (r_state == ST_HOLD) && r_acc_valid && acc_ready;
    assign w_clear     = start && ((r_state == ST_IDLE) || w_handshake);

    // One extra bit of headroom exposes the carry used as the overflow event.
    always_comb begin
        w_sum_wide = {1'b0, r_acc} + {{(ACC_WIDTH - ADDER_WIDTH){1'b0}}, sum};
        w_carry    = w_sum_wide[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
        w_acc_next = w_carry ? C_ACC_MAX : w_sum_wide[ACC_WIDTH-1:0];
`else
        w_acc_next = w_sum_wide[ACC_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_last) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    w_next_state = start ? ST_ACCUM : ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_acc_out   <= '0;
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);

            if (w_clear) begin
                r_acc      <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_dropped  <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 1'b1;
                    if (w_carry) begin
                        r_overflow <= 1'b1;
                    end
                end
                if (sum_valid && (r_state != ST_ACCUM)) begin
                    r_dropped <= 1'b1;
                end
            end

            // The block total includes the sample that completes the block.
            if (w_last) begin
                r_acc_out   <= w_acc_next;
                r_acc_valid <= 1'b1;
            end else if (w_handshake) begin
                r_acc_valid <= 1'b0;
            end
        end
    end

    assign acc_out   = r_acc_out;
    assign acc_valid = r_acc_valid;
    assign busy      = r_busy;
    assign overflow  = r_overflow;
    assign dropped   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_adder_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_sum_accumulator
// Purpose  : Randomized self-checking bench for adder_sum_accumulator, with a
//            default-size instance and a narrow instance for overflow cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_sum_accumulator;

    localparam int AW  = 13;
    localparam int ACW = 24;
    localparam int BL  = 16;
    localparam int NW  = 16;
    localparam int NBL = 8;
`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start, sum_valid, acc_ready;
    logic [AW:0]     sum;
    logic [ACW-1:0]  acc_out;
    logic            acc_valid, busy, overflow, dropped;

    logic            n_start, n_valid, n_ready;
    logic [AW:0]     n_sum;
    logic [NW-1:0]   n_out;
    logic            n_acc_valid, n_busy, n_overflow, n_dropped;

    int checks   = 0;
    int failures = 0;

    adder_sum_accumulator #(.ADDER_WIDTH(AW), .ACC_WIDTH(ACW), .BLOCK_LEN(BL), .CNT_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .start(start), .sum_valid(sum_valid), .sum(sum),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .busy(busy), .overflow(overflow), .dropped(dropped)
    );

    adder_sum_accumulator #(.ADDER_WIDTH(AW), .ACC_WIDTH(NW), .BLOCK_LEN(NBL), .CNT_WIDTH(4)) dut_narrow (
        .clk(clk), .reset(reset), .start(n_start), .sum_valid(n_valid), .sum(n_sum),
        .acc_out(n_out), .acc_valid(n_acc_valid), .acc_ready(n_ready),
        .busy(n_busy), .overflow(n_overflow), .dropped(n_dropped)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; sum_valid = 0; sum = '0; acc_ready = 0;
        n_start = 0; n_valid = 0; n_sum = '0; n_ready = 0;
    endtask

    // Reference for a block: true sum, then wrapped or clamped to the width.
    function automatic longint model_total(input longint total, input int width);
        longint maxv = (longint'(1) << width) - 1;
        if (SAT) return (total > maxv) ? maxv : total;
        return total % (maxv + 1);
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset = 1; step(); step(); reset = 0;
        checks++;
        if ({acc_out, acc_valid, busy, overflow, dropped} !== '0) begin
            failures++;
            $display("FAIL reset_main got out=%0d v=%0b b=%0b o=%0b d=%0b exp all 0",
                     acc_out, acc_valid, busy, overflow, dropped);
        end
        checks++;
        if ({n_out, n_acc_valid, n_busy, n_overflow, n_dropped} !== '0) begin
            failures++;
            $display("FAIL reset_narrow got out=%0d v=%0b exp all 0", n_out, n_acc_valid);
        end
    endtask

    task automatic test_basic();
        start = 1; step(); start = 0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        for (int i = 1; i <= 16; i++) begin
            sum_valid = 1; sum = (AW+1)'(i); step();
            if (i == 15) begin
                checks++;
                if (acc_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", acc_valid); end
            end
        end
        sum_valid = 0;
        checks++;
        if (acc_valid !== 1'b1 || acc_out !== 24'd136 || overflow !== 1'b0 || dropped !== 1'b0) begin
            failures++;
            $display("FAIL basic_total got v=%0b out=%0d o=%0b d=%0b exp v=1 out=136 o=0 d=0",
                     acc_valid, acc_out, overflow, dropped);
        end
        acc_ready = 1; step(); acc_ready = 0;
        checks++;
        if (acc_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_handshake got v=%0b b=%0b exp v=0 b=0", acc_valid, busy);
        end
        sum_valid = 1; sum = 14'd5; step(); sum_valid = 0;
        checks++;
        if (dropped !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_drop got d=%0b b=%0b exp d=1 b=0", dropped, busy);
        end
    endtask

    task automatic test_gaps();
        start = 1; step(); start = 0;
        checks++;
        if (dropped !== 1'b0) begin failures++; $display("FAIL gaps_drop_clear got=%0b exp=0", dropped); end
        for (int i = 1; i <= 16; i++) begin
            sum_valid = 1; sum = (AW+1)'(i); step();
            sum_valid = 0;
            if (i < 16) begin
                step();
                if (i == 15) begin
                    checks++;
                    if (acc_valid !== 1'b0) begin failures++; $display("FAIL gaps_early_valid got=%0b exp=0", acc_valid); end
                end
            end
        end
        checks++;
        if (acc_valid !== 1'b1 || acc_out !== 24'd136) begin
            failures++; $display("FAIL gaps_total got v=%0b out=%0d exp v=1 out=136", acc_valid, acc_out);
        end
        acc_ready = 1; step(); acc_ready = 0;
    endtask

    task automatic test_backpressure();
        start = 1; step(); start = 0;
        for (int i = 0; i < 16; i++) begin sum_valid = 1; sum = 14'd100; step(); end
        for (int i = 0; i < 3; i++) begin
            sum_valid = 1; sum = 14'd77; step();
            checks++;
            if (acc_valid !== 1'b1 || acc_out !== 24'd1600) begin
                failures++; $display("FAIL bp_hold got v=%0b out=%0d exp v=1 out=1600", acc_valid, acc_out);
            end
        end
        sum_valid = 0;
        checks++;
        if (dropped !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL bp_dropped got d=%0b b=%0b exp d=1 b=1", dropped, busy);
        end
        acc_ready = 1; step(); acc_ready = 0;
        checks++;
        if (acc_valid !== 1'b0 || dropped !== 1'b1) begin
            failures++; $display("FAIL bp_release got v=%0b d=%0b exp v=0 d=1", acc_valid, dropped);
        end
    endtask

    task automatic test_narrow_overflow();
        longint exp_v = model_total(longint'(8) * 16383, NW);
        n_start = 1; step(); n_start = 0;
        for (int i = 0; i < NBL; i++) begin n_valid = 1; n_sum = 14'd16383; step(); end
        n_valid = 0;
        checks++;
        if (n_acc_valid !== 1'b1 || n_out !== NW'(exp_v) || n_overflow !== 1'b1) begin
            failures++; $display("FAIL narrow_ovf got v=%0b out=%0d o=%0b exp v=1 out=%0d o=1",
                                 n_acc_valid, n_out, n_overflow, exp_v);
        end
        n_ready = 1; step(); n_ready = 0;
        checks++;
        if (n_overflow !== 1'b1 || n_busy !== 1'b0) begin
            failures++; $display("FAIL narrow_sticky got o=%0b b=%0b exp o=1 b=0", n_overflow, n_busy);
        end
    endtask

    task automatic test_reset_mid();
        start = 1; step(); start = 0;
        for (int i = 0; i < 5; i++) begin sum_valid = 1; sum = 14'd900; step(); end
        sum_valid = 0;
        reset = 1; step(); reset = 0;
        checks++;
        if ({acc_out, acc_valid, busy, overflow, dropped} !== '0) begin
            failures++; $display("FAIL reset_mid got out=%0d v=%0b b=%0b exp all 0", acc_out, acc_valid, busy);
        end
        start = 1; step(); start = 0;
        for (int i = 0; i < 16; i++) begin sum_valid = 1; sum = 14'd2; step(); end
        sum_valid = 0;
        checks++;
        if (acc_valid !== 1'b1 || acc_out !== 24'd32) begin
            failures++; $display("FAIL reset_residue got v=%0b out=%0d exp v=1 out=32", acc_valid, acc_out);
        end
    endtask

    // Entered with a block waiting in HOLD.
    task automatic test_back_to_back();
        sum_valid = 1; sum = 14'd1; step(); sum_valid = 0;
        start = 1; acc_ready = 1; step(); start = 0; acc_ready = 0;
        checks++;
        if (acc_valid !== 1'b0 || busy !== 1'b1 || dropped !== 1'b0) begin
            failures++; $display("FAIL b2b_restart got v=%0b b=%0b d=%0b exp v=0 b=1 d=0", acc_valid, busy, dropped);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin start = 1; step(); start = 0; end
            sum_valid = 1; sum = 14'd3; step();
        end
        sum_valid = 0;
        checks++;
        if (acc_valid !== 1'b1 || acc_out !== 24'd48) begin
            failures++; $display("FAIL b2b_total got v=%0b out=%0d exp v=1 out=48", acc_valid, acc_out);
        end
        acc_ready = 1; step(); acc_ready = 0;
    endtask

    task automatic test_random();
        bit chained = 0;
        for (int blk = 0; blk < 6; blk++) begin
            longint total = 0;
            int     got = 0;
            int     guard = 0;
            bit     exp_drop = 0;
            if (!chained) begin start = 1; step(); start = 0; end
            while (got < BL && guard < 200) begin
                logic [AW:0] v = (AW+1)'($urandom_range(0, 16383));
                sum_valid = ($urandom_range(0, 9) < 7);
                sum = v;
                start = ($urandom_range(0, 9) == 0);
                if (sum_valid) begin total += v; got++; end
                step();
                guard++;
                checks++;
                if (acc_valid !== (got == BL)) begin
                    failures++; $display("FAIL rand_valid blk=%0d got=%0b exp=%0b", blk, acc_valid, got == BL);
                end
            end
            start = 0; sum_valid = 0;
            for (int w = $urandom_range(0, 3); w > 0; w--) begin
                sum_valid = $urandom_range(0, 1);
                if (sum_valid) exp_drop = 1;
                step();
            end
            sum_valid = 0;
            checks++;
            if (acc_valid !== 1'b1 || acc_out !== ACW'(model_total(total, ACW)) ||
                overflow !== 1'b0 || dropped !== exp_drop) begin
                failures++;
                $display("FAIL rand_block blk=%0d got v=%0b out=%0d o=%0b d=%0b exp v=1 out=%0d o=0 d=%0b",
                         blk, acc_valid, acc_out, overflow, dropped, model_total(total, ACW), exp_drop);
            end
            chained = $urandom_range(0, 1);
            start = chained; acc_ready = 1; step(); start = 0; acc_ready = 0;
            checks++;
            if (acc_valid !== 1'b0 || busy !== chained) begin
                failures++; $display("FAIL rand_release blk=%0d got v=%0b b=%0b exp v=0 b=%0b",
                                     blk, acc_valid, busy, chained);
            end
        end
        if (chained) begin
            for (int i = 0; i < BL; i++) begin sum_valid = 1; sum = '0; step(); end
            sum_valid = 0; acc_ready = 1; step(); acc_ready = 0;
        end
    endtask

    task automatic test_random_narrow();
        for (int blk = 0; blk < 4; blk++) begin
            longint total = 0;
            n_start = 1; step(); n_start = 0;
            for (int i = 0; i < NBL; i++) begin
                logic [AW:0] v = (AW+1)'($urandom_range(4000, 16383));
                total += v;
                n_valid = 1; n_sum = v; step();
            end
            n_valid = 0;
            checks++;
            if (n_acc_valid !== 1'b1 || n_out !== NW'(model_total(total, NW)) ||
                n_overflow !== (total > 65535)) begin
                failures++;
                $display("FAIL rand_narrow blk=%0d got out=%0d o=%0b exp out=%0d o=%0b",
                         blk, n_out, n_overflow, model_total(total, NW), total > 65535);
            end
            n_ready = 1; step(); n_ready = 0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_narrow_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_random_narrow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
